// File: rtl/vproc_pkg.sv
// vproc_pkg: shared decode types, opcode constants and field widths for the vector decode stage
package vproc_pkg;
  localparam int OPC_W = 3;
  localparam int WB_W = 2;
  localparam int EX_W = 5;
  localparam int MEM_W = 4;
  localparam int RT_W = 3;
  localparam int BUNDLE_FIXED_W = EX_W + MEM_W + WB_W + RT_W + 1;
  typedef enum logic [RT_W-1:0] {
    RT_S2V = 3'b000,
    RT_VS  = 3'b001,
    RT_S   = 3'b010,
    RT_VV  = 3'b011,
    RT_SI  = 3'b100,
    RT_SS  = 3'b101
  } regtype_e;
  localparam logic [OPC_W-1:0] OP_MOV = 3'b000;
  localparam logic [OPC_W-1:0] OP_S2V = 3'b001;
  localparam logic [OPC_W-1:0] OP_BRA = 3'b010;
  localparam logic [OPC_W-1:0] OP_BRB = 3'b011;
  localparam logic [OPC_W-1:0] OP_VSA = 3'b100;
  localparam logic [OPC_W-1:0] OP_VV  = 3'b101;
  localparam logic [OPC_W-1:0] OP_VSB = 3'b110;
  localparam logic [OPC_W-1:0] OP_SS  = 3'b111;
  typedef struct packed {
    regtype_e rt;
    logic     dt;
    logic     imm_sel;
  } dec_attr_t;
  // load/store (funct=1) shares the vector-scalar operand shape
  function automatic dec_attr_t dec_attr(input logic funct, input logic [OPC_W-1:0] opcode);
    dec_attr_t a;
    a = '{RT_VS, 1'b1, 1'b0};
    if (!funct) begin
      case (opcode)
        OP_MOV:         a = '{RT_S, 1'b0, 1'b1};
        OP_S2V:         a = '{RT_S2V, 1'b1, 1'b0};
        OP_BRA, OP_BRB: a = '{RT_SI, 1'b0, 1'b1};
        OP_VSA, OP_VSB: a = '{RT_VS, 1'b1, 1'b0};
        OP_VV:          a = '{RT_VV, 1'b1, 1'b0};
        default:        a = '{RT_SS, 1'b0, 1'b0};
      endcase
    end
    return a;
  endfunction
endpackage

// File: rtl/vdec_fields.sv
// vdec_fields: combinational split of an instruction into its decoded bundle and register masks
module vdec_fields
  import vproc_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int IMM_W = 8,
  localparam int INSTR_W = 6 + 2 * REG_AW + IMM_W,
  localparam int NR = 2 ** REG_AW
) (
  input  logic [INSTR_W-1:0] i_instr,
  output logic [EX_W-1:0]    o_ex,
  output logic [MEM_W-1:0]   o_mem,
  output logic [WB_W-1:0]    o_wb,
  output logic [REG_AW-1:0]  o_oper1,
  output logic [REG_AW-1:0]  o_oper2,
  output logic [REG_AW-1:0]  o_oper3,
  output logic [IMM_W-1:0]   o_imm,
  output logic [RT_W-1:0]    o_regtype,
  output logic               o_destype,
  output logic [NR-1:0]      o_src_s,
  output logic [NR-1:0]      o_src_v,
  output logic [NR-1:0]      o_dst_s,
  output logic [NR-1:0]      o_dst_v
);
  localparam logic [NR-1:0] ONE = 1;
  logic              w_funct;
  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_o1, w_o2, w_o3;
  logic [NR-1:0]     w_m1, w_m2, w_m3;
  logic              w_use2, w_use3;
  dec_attr_t         w_attr;
  regtype_e          w_rt;
  assign {w_funct, w_opc, o_wb, w_o1, w_o2, o_imm} = i_instr;
  assign w_o3 = o_imm[IMM_W-1 -: REG_AW];
  assign w_attr = dec_attr(w_funct, w_opc);
  assign w_rt = w_attr.rt;
  assign w_use2 = w_rt inside {RT_S2V, RT_VS, RT_VV, RT_SS};
  assign w_use3 = w_rt inside {RT_VS, RT_VV, RT_SS};
  assign o_ex = {w_funct, w_opc, w_attr.imm_sel};
  assign o_mem = {w_funct, w_opc};
  assign o_oper1 = w_o1;
  assign o_oper2 = w_use2 ? w_o2 : '0;
  assign o_oper3 = w_use3 ? w_o3 : '0;
  assign o_regtype = w_rt;
  assign o_destype = w_attr.dt;
  assign w_m1 = ONE << w_o1;
  assign w_m2 = ONE << w_o2;
  assign w_m3 = ONE << w_o3;
  // immediate-form branches read their scalar from oper1
  assign o_src_s = (w_rt == RT_SI ? w_m1 : '0)
                 | (w_rt == RT_S2V || w_rt == RT_SS ? w_m2 : '0)
                 | (w_rt == RT_VS || w_rt == RT_SS ? w_m3 : '0);
  assign o_src_v = (w_rt == RT_VS || w_rt == RT_VV ? w_m2 : '0)
                 | (w_rt == RT_VV ? w_m3 : '0);
  assign o_dst_s = o_wb[0] && !w_attr.dt ? w_m1 : '0;
  assign o_dst_v = o_wb[0] && w_attr.dt ? w_m1 : '0;
endmodule

// File: rtl/vector_decode_stage.sv
// vector_decode_stage: registered decode stage with scalar/vector scoreboard hazard stalls
module vector_decode_stage
  import vproc_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int IMM_W = 8,
  parameter int CNT_W = 16,
  localparam int INSTR_W = 6 + 2 * REG_AW + IMM_W,
  localparam int NR = 2 ** REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic               wb_vec,
  input  logic [REG_AW-1:0]  wb_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EX_W-1:0]    out_ex,
  output logic [MEM_W-1:0]   out_mem,
  output logic [WB_W-1:0]    out_wb,
  output logic [REG_AW-1:0]  out_oper1,
  output logic [REG_AW-1:0]  out_oper2,
  output logic [REG_AW-1:0]  out_oper3,
  output logic [IMM_W-1:0]   out_imm,
  output logic [RT_W-1:0]    out_regtype,
  output logic               out_destype,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam int BW = BUNDLE_FIXED_W + 3 * REG_AW + IMM_W;
  localparam logic [NR-1:0] ONE = 1;
  logic [EX_W-1:0]   w_ex;
  logic [MEM_W-1:0]  w_mem;
  logic [WB_W-1:0]   w_wb;
  logic [REG_AW-1:0] w_o1, w_o2, w_o3;
  logic [IMM_W-1:0]  w_imm;
  logic [RT_W-1:0]   w_rt;
  logic              w_dt, w_hazard, w_acc;
  logic [NR-1:0]     w_src_s, w_src_v, w_dst_s, w_dst_v, w_clr_s, w_clr_v;
  logic [BW-1:0]     w_bundle, r_bundle;
  logic [NR-1:0]     r_pend_s, r_pend_v;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall;
  vdec_fields #(.REG_AW(REG_AW), .IMM_W(IMM_W)) u_fields (
    .i_instr(in_instr), .o_ex(w_ex), .o_mem(w_mem), .o_wb(w_wb),
    .o_oper1(w_o1), .o_oper2(w_o2), .o_oper3(w_o3), .o_imm(w_imm),
    .o_regtype(w_rt), .o_destype(w_dt),
    .o_src_s(w_src_s), .o_src_v(w_src_v), .o_dst_s(w_dst_s), .o_dst_v(w_dst_v)
  );
  assign w_bundle = {w_ex, w_mem, w_wb, w_o1, w_o2, w_o3, w_imm, w_rt, w_dt};
  // hazard looks only at the registered scoreboard; a same-cycle writeback does not bypass
  assign w_hazard = |((w_src_s | w_dst_s) & r_pend_s) | |((w_src_v | w_dst_v) & r_pend_v);
  assign in_ready = rst_n & (!r_valid | out_ready) & !w_hazard & !flush;
  assign w_acc = in_valid & in_ready;
  assign w_clr_s = wb_valid && !wb_vec ? ONE << wb_addr : '0;
  assign w_clr_v = wb_valid && wb_vec ? ONE << wb_addr : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bundle <= '0;
      r_pend_s <= '0;
      r_pend_v <= '0;
      r_stall <= '0;
    end else begin
      r_valid <= w_acc | (r_valid & !out_ready & !flush);
      if (w_acc) r_bundle <= w_bundle;
      r_pend_s <= (r_pend_s & ~w_clr_s) | (w_acc ? w_dst_s : '0);
      r_pend_v <= (r_pend_v & ~w_clr_v) | (w_acc ? w_dst_v : '0);
      if (in_valid && w_hazard && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
    end
  end
  assign out_valid = r_valid;
  assign {out_ex, out_mem, out_wb, out_oper1, out_oper2, out_oper3, out_imm, out_regtype, out_destype} = r_bundle;
  assign stall_cnt = r_stall;
endmodule

// File: tb/tb_vector_decode_stage.sv
// tb_vector_decode_stage: directed and random stimulus against a queue-based reference model
module tb_vector_decode_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, wb_valid = 0, wb_vec = 0, out_ready = 1;
  logic [19:0] in_instr = 0;
  logic [2:0] wb_addr = 0;
  logic in_ready, out_valid, out_destype;
  logic [4:0] out_ex;
  logic [3:0] out_mem, stall_cnt;
  logic [1:0] out_wb;
  logic [2:0] out_oper1, out_oper2, out_oper3, out_regtype;
  logic [7:0] out_imm;
  logic [31:0] dut_b;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_sp = 0, m_vp = 0;
  logic m_ov = 0;
  int m_cnt = 0;
  logic [31:0] exp_q[$];
  int rt_tab[8] = '{2, 0, 4, 4, 1, 3, 1, 5};
  int dt_tab[8] = '{0, 1, 0, 0, 1, 1, 1, 0};
  int is_tab[8] = '{1, 0, 1, 1, 0, 0, 0, 0};

  always #5 clk = ~clk;

  vector_decode_stage #(.REG_AW(3), .IMM_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .wb_valid(wb_valid), .wb_vec(wb_vec), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ex(out_ex), .out_mem(out_mem),
    .out_wb(out_wb), .out_oper1(out_oper1), .out_oper2(out_oper2), .out_oper3(out_oper3),
    .out_imm(out_imm), .out_regtype(out_regtype), .out_destype(out_destype), .stall_cnt(stall_cnt)
  );
  assign dut_b = {out_ex, out_mem, out_wb, out_oper1, out_oper2, out_oper3, out_imm, out_regtype, out_destype};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_bundle(input logic [19:0] x);
    logic f, dt, is;
    logic [2:0] op, rt, o2, o3;
    f = x[19];
    op = x[18:16];
    rt = f ? 3'd1 : 3'(rt_tab[op]);
    dt = f ? 1'b1 : 1'(dt_tab[op]);
    is = f ? 1'b0 : 1'(is_tab[op]);
    o2 = (rt inside {3'd0, 3'd1, 3'd3, 3'd5}) ? x[10:8] : 3'd0;
    o3 = (rt inside {3'd1, 3'd3, 3'd5}) ? x[7:5] : 3'd0;
    return {f, op, is, f, op, x[15:14], x[13:11], o2, o3, x[7:0], rt, dt};
  endfunction

  function automatic logic ref_hazard(input logic [19:0] x);
    logic [31:0] b;
    logic [2:0] o1, o2, o3;
    logic h;
    b = ref_bundle(x);
    o1 = x[13:11];
    o2 = x[10:8];
    o3 = x[7:5];
    case (b[3:1])
      3'd4:    h = m_sp[o1];
      3'd1:    h = m_sp[o3] | m_vp[o2];
      3'd3:    h = m_vp[o2] | m_vp[o3];
      3'd5:    h = m_sp[o2] | m_sp[o3];
      3'd0:    h = m_sp[o2];
      default: h = 1'b0;
    endcase
    if (x[14]) h = h | (b[0] ? m_vp[o1] : m_sp[o1]);
    return h;
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] b;
    logic [7:0] sp, vp;
    logic hz, acc;
    if (!rst_n) begin
      m_sp <= 0;
      m_vp <= 0;
      m_ov <= 0;
      m_cnt <= 0;
      exp_q.delete();
    end else begin
      hz = ref_hazard(in_instr);
      acc = in_valid && (!m_ov || out_ready) && !hz && !flush;
      sp = m_sp;
      vp = m_vp;
      if (wb_valid) begin
        if (wb_vec) vp[wb_addr] = 1'b0;
        else sp[wb_addr] = 1'b0;
      end
      if (flush && m_ov && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        b = ref_bundle(in_instr);
        exp_q.push_back(b);
        if (in_instr[14]) begin
          if (b[0]) vp[in_instr[13:11]] = 1'b1;
          else sp[in_instr[13:11]] = 1'b1;
        end
      end
      m_sp <= sp;
      m_vp <= vp;
      m_ov <= acc || (m_ov && !out_ready && !flush);
      if (in_valid && hz && m_cnt < 15) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin : monitor
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("in_ready", 32'(in_ready), 32'(rst_n && (!m_ov || out_ready) && !ref_hazard(in_instr) && !flush));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) chk("unexpected_output", 32'(out_valid), 0);
      else chk("bundle", dut_b, exp_q.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] x);
    logic done = 0;
    in_instr = x;
    in_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      step();
    end
    in_valid = 0;
    if (!done) chk("send_timeout", 32'(done), 1);
  endtask

  initial begin
    step(2);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bundle", dut_b, 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    step();
    rst_n = 1;
    out_ready = 0;
    send(20'h0505A);
    @(negedge clk);
    chk("mov_valid", 32'(out_valid), 1);
    chk("mov_oper1", 32'(out_oper1), 2);
    chk("mov_imm", 32'(out_imm), 32'h5A);
    chk("mov_regtype", 32'(out_regtype), 3'b010);
    chk("mov_destype", 32'(out_destype), 0);
    chk("mov_ex", 32'(out_ex), 5'b00001);
    step();
    in_instr = 20'h10200;
    out_ready = 1;
    @(negedge clk);
    chk("s2_pending", 32'(in_ready), 0);
    step();
    wb_valid = 1; wb_vec = 0; wb_addr = 2;
    step();
    wb_valid = 0;
    @(negedge clk);
    chk("s2_cleared", 32'(in_ready), 1);
    step();
    send(20'h55800);
    in_instr = 20'h54A60;
    in_valid = 1;
    step(3);
    wb_valid = 1; wb_vec = 1; wb_addr = 3;
    @(negedge clk);
    chk("vadd_stall3", 32'(stall_cnt), 3);
    chk("vadd_blocked", 32'(in_ready), 0);
    step();
    wb_valid = 0;
    @(negedge clk);
    chk("vadd_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("vadd_valid", 32'(out_valid), 1);
    chk("vadd_regtype", 32'(out_regtype), 3'b011);
    chk("vadd_opers", {out_oper1, out_oper2, out_oper3}, {3'd1, 3'd2, 3'd3});
    chk("vadd_stall4", 32'(stall_cnt), 4);
    step();
    out_ready = 0;
    send(20'h02A05);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_bundle", dut_b, ref_bundle(20'h02A05));
      step();
    end
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_instr = {1'b0, 3'b000, 2'b10, 3'(i), 3'(i + 1), 8'($urandom)};
      in_valid = 1;
      @(negedge clk);
      chk("b2b_ready", 32'(in_ready), 1);
      step();
    end
    in_valid = 0;
    wb_valid = 1; wb_vec = 1; wb_addr = 1;
    step();
    in_instr = 20'h54A60;
    in_valid = 1;
    @(negedge clk);
    chk("setclr_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    wb_valid = 0;
    in_instr = 20'h50100;
    @(negedge clk);
    chk("v1_set_wins", 32'(in_ready), 0);
    step();
    out_ready = 0;
    send(20'h06011);
    flush = 1;
    @(negedge clk);
    chk("flush_blocks", 32'(in_ready), 0);
    chk("flush_pre_valid", 32'(out_valid), 1);
    step();
    flush = 0;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 0);
    step();
    in_instr = 20'h10400;
    in_valid = 1;
    step(2);
    @(negedge clk);
    chk("s4_still_pending", 32'(in_ready), 0);
    step();
    rst_n = 0; flush = 1; wb_valid = 1; wb_vec = 0; wb_addr = 4;
    @(negedge clk);
    chk("rst_ready_low", 32'(in_ready), 0);
    step();
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_bundle", dut_b, 0);
    chk("midrst_stall", 32'(stall_cnt), 0);
    step();
    rst_n = 1; flush = 0; wb_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    send(20'h07001);
    in_instr = 20'h10600;
    in_valid = 1;
    step(20);
    @(negedge clk);
    chk("stall_sat", 32'(stall_cnt), 4'hF);
    step();
    in_valid = 0;
    wb_valid = 1; wb_vec = 0; wb_addr = 6;
    step();
    wb_valid = 0;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom % 100) != 0;
      in_valid = $urandom % 2;
      in_instr = 20'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 20) == 0;
      wb_valid = ($urandom % 3) == 0;
      wb_vec = $urandom % 2;
      wb_addr = 3'($urandom);
      step();
    end
    in_valid = 0; flush = 0; wb_valid = 0; out_ready = 1; rst_n = 1;
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
